fc_layer_sequencer: RTL and testbench

Fully-connected layer engine that drives the shared 16-bit single-port activation/weight RAM. On `start` it reads FRT_CELL input activations and FRT_CELL×BCK_CELL weights through the RAM's address port. It multiply-accumulates them in signed Q8.8 and writes BCK_CELL saturated results back into the same RAM. It is the address/data master sitting directly in front of the RAM: it feeds `addr`/`data`/`we` and consumes `q`.

---
 rtl/fc_pkg.sv | 40 ++++
 rtl/fc_mac_unit.sv | 55 +++++
 rtl/fc_layer_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Brief    : Shared types and constants for the fully-connected layer engine.
// Revision : 1.0
// ============================================================================
package fc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR_X = 3'd1;
    localparam logic [2:0] ST_ADDR_W = 3'd2;
    localparam logic [2:0] ST_MAC    = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ADDR_X = ST_ADDR_X,
        S_ADDR_W = ST_ADDR_W,
        S_MAC    = ST_MAC,
        S_WRITE  = ST_WRITE,
        S_DONE   = ST_DONE
    } fc_state_t;

    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] SAT_MAX   = 16'h7FFF;
    localparam logic [15:0] SAT_MIN   = 16'h8000;

    // Unsigned bits needed to hold value; never less than 1.
    function automatic int bits_required(input int value);
        int n;
        n = 1;
        for (int k = 1; k < 31; k++) begin
            if (value >= (1 << k)) n = k + 1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_unit
// Brief    : Signed Q8.8 multiply-accumulate with Q8.8 shift/saturate output.
// Revision : 1.0
// ============================================================================
module fc_mac_unit
    import fc_pkg::*;
#(
    parameter int ACC_W = 36
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_scaled;
    logic        [ACC_W-16:0] w_upper;

    assign w_prod     = $signed(a) * $signed(b);
    assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
    assign w_acc_next = en ? (r_acc + w_prod_ext) : r_acc;

    // Result reflects the accumulator including this cycle's product so the
    // sequencer can register it on the same edge as the final MAC.
    assign w_scaled = w_acc_next >>> FRAC_BITS;
    assign w_upper  = w_scaled[ACC_W-1:15];

    always_comb begin
        result = w_scaled[15:0];
        if (!((&w_upper) | ~(|w_upper))) begin
            result = w_scaled[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_sequencer
// Brief    : Fully-connected layer RAM master: reads x and w, MACs, writes y.
// Revision : 1.0
// ============================================================================
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int FRT_CELL = 10,
    parameter int BCK_CELL = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in_base,
    input  logic [15:0] w_base,
    input  logic [15:0] out_base,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        ram_we,
    input  logic [15:0] ram_q,
    output logic        busy,
    output logic        done
);

    localparam int ACC_W = 32 + bits_required(FRT_CELL);
    localparam int I_W   = bits_required(FRT_CELL - 1);
    localparam int J_W   = bits_required(BCK_CELL - 1);
    localparam logic [I_W-1:0] C_I_LAST = I_W'(FRT_CELL - 1);
    localparam logic [J_W-1:0] C_J_LAST = J_W'(BCK_CELL - 1);

    fc_state_t      r_state;
    fc_state_t      w_state_next;
    logic [I_W-1:0] r_i;
    logic [J_W-1:0] r_j;
    logic [15:0]    r_in_base;
    logic [15:0]    r_out_base;
    logic [15:0]    r_w_ptr;
    logic [15:0]    r_x;
    logic [15:0]    w_addr_next;
    logic [15:0]    w_data_next;
    logic           w_we_next;
    logic           w_busy_next;
    logic           w_done_next;
    logic           w_acc_clr;
    logic           w_acc_en;
    logic [15:0]    w_mac_result;
    logic           w_i_last;
    logic           w_j_last;

    assign w_i_last = (r_i == C_I_LAST);
    assign w_j_last = (r_j == C_J_LAST);

    fc_mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_acc_clr),
        .en     (w_acc_en),
        .a      (r_x),
        .b      (ram_q),
        .result (w_mac_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output values are chosen for the state being entered, so the registered
    // RAM port lines up with the state that owns it.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = 16'h0000;
        w_data_next  = 16'h0000;
        w_we_next    = 1'b0;
        w_busy_next  = 1'b1;
        w_done_next  = 1'b0;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
                if (start) begin
                    w_state_next = S_ADDR_X;
                    w_addr_next  = in_base;
                    w_busy_next  = 1'b1;
                    w_acc_clr    = 1'b1;
                end
            end
            S_ADDR_X: begin
                w_state_next = S_ADDR_W;
                w_addr_next  = r_w_ptr;
            end
            S_ADDR_W: begin
                w_state_next = S_MAC;
                w_addr_next  = r_w_ptr;
            end
            S_MAC: begin
                w_acc_en = 1'b1;
                if (w_i_last) begin
                    w_state_next = S_WRITE;
                    w_we_next    = 1'b1;
                    w_addr_next  = r_out_base + 16'(r_j);
                    w_data_next  = w_mac_result;
                end else begin
                    w_state_next = S_ADDR_X;
                    w_addr_next  = r_in_base + 16'(r_i) + 16'd1;
                end
            end
            S_WRITE: begin
                w_acc_clr = 1'b1;
                if (w_j_last) begin
                    w_state_next = S_DONE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = S_ADDR_X;
                    w_addr_next  = r_in_base;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= 16'h0000;
            ram_data   <= 16'h0000;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_in_base  <= 16'h0000;
            r_out_base <= 16'h0000;
            r_w_ptr    <= 16'h0000;
            r_x        <= 16'h0000;
        end else begin
            ram_addr <= w_addr_next;
            ram_data <= w_data_next;
            ram_we   <= w_we_next;
            busy     <= w_busy_next;
            done     <= w_done_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_base  <= in_base;
                        r_out_base <= out_base;
                        r_w_ptr    <= w_base;
                        r_i        <= '0;
                        r_j        <= '0;
                    end
                end
                // Weights are stored row-major in visit order, so one
                // linear pointer walks every w[j][i] across all rows.
                S_ADDR_W: begin
                    r_x     <= ram_q;
                    r_w_ptr <= r_w_ptr + 16'd1;
                end
                S_MAC: begin
                    if (!w_i_last) r_i <= r_i + I_W'(1);
                end
                S_WRITE: begin
                    r_i <= '0;
                    if (!w_j_last) r_j <= r_j + J_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_layer_sequencer
// Brief    : Directed self-checking bench for fc_layer_sequencer with RAM model.
// Revision : 1.0
// ============================================================================
module tb_fc_layer_sequencer;

    localparam int FRT = 10;
    localparam int BCK = 5;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] in_base  = 16'h0000;
    logic [15:0] w_base   = 16'h0000;
    logic [15:0] out_base = 16'h0000;
    logic [15:0] ram_addr;
    logic [15:0] ram_data;
    logic [15:0] ram_q;
    logic        ram_we;
    logic        busy;
    logic        done;

    fc_layer_sequencer #(
        .FRT_CELL (FRT),
        .BCK_CELL (BCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_base  (in_base),
        .w_base   (w_base),
        .out_base (out_base),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic        bd_we   = 1'b0;
    logic [15:0] bd_addr = 16'h0000;
    logic [15:0] bd_data = 16'h0000;

    always @(posedge clk) begin
        if (ram_we)     mem[ram_addr] <= ram_data;
        else if (bd_we) mem[bd_addr]  <= bd_data;
        ram_q <= mem[ram_addr];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          bad_wr   = 0;
    int          bad_rd   = 0;
    int          done_cnt = 0;
    logic [15:0] wr_lo    = 16'h0200;
    logic [15:0] wr_hi    = 16'h0204;
    logic        rd_chk   = 1'b0;

    function automatic logic rd_ok(input logic [15:0] a);
        return (a >= 16'hFFFC) || (a <= 16'h0005) || (a >= 16'h0100 && a <= 16'h0131);
    endfunction

    always @(negedge clk) begin
        if (ram_we) begin
            wr_cnt++;
            if (ram_addr < wr_lo || ram_addr > wr_hi) bad_wr++;
        end
        if (done) done_cnt++;
        if (rd_chk && busy && !ram_we && !rd_ok(ram_addr)) bad_rd++;
    end

    logic [15:0] xv [FRT];
    logic [15:0] wv [BCK][FRT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
    endtask

    task automatic load_layer(input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] ob);
        for (int i = 0; i < FRT; i++) poke(16'(ib + i), xv[i]);
        for (int j = 0; j < BCK; j++)
            for (int i = 0; i < FRT; i++) poke(16'(wb + j*FRT + i), wv[j][i]);
        for (int j = 0; j <= BCK; j++) poke(16'(ob + j), 16'hDEAD);
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic start_layer(input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] ob);
        @(negedge clk);
        in_base  = ib;
        w_base   = wb;
        out_base = ob;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_base  = 16'h5555;
        w_base   = 16'h5555;
        out_base = 16'h5555;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_layer(input string tag, input logic [15:0] ib, input logic [15:0] wb,
                             input logic [15:0] ob);
        int cyc;
        int wr0;
        int d0;
        load_layer(ib, wb, ob);
        wr0 = wr_cnt;
        d0  = done_cnt;
        start_layer(ib, wb, ob);
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check({tag, "_addr_x0"}, 32'(ram_addr), 32'(ib));
        @(posedge clk);
        #1;
        check({tag, "_addr_w0"}, 32'(ram_addr), 32'(wb));
        wait_done(2, cyc);
        check({tag, "_done_cyc"}, 32'(cyc), 32'd156);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cyc"}, 32'(done), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_wr_cnt"}, 32'(wr_cnt - wr0), 32'(BCK));
    endtask

    task automatic check_const(input string tag, input logic [15:0] ob, input logic [15:0] v);
        for (int j = 0; j < BCK; j++) check($sformatf("%s_y%0d", tag, j), 32'(mem[16'(ob + j)]), 32'(v));
        check({tag, "_past_end"}, 32'(mem[16'(ob + BCK)]), 32'h0000DEAD);
    endtask

    function automatic logic [15:0] golden(input int j);
        longint acc;
        acc = 0;
        for (int i = 0; i < FRT; i++)
            acc += longint'($signed(xv[i])) * longint'($signed(wv[j][i]));
        acc = acc >>> 8;
        if (acc > 32767)  return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    task automatic fill(input logic [15:0] x, input logic [15:0] w);
        for (int i = 0; i < FRT; i++) begin
            xv[i] = x;
            for (int j = 0; j < BCK; j++) wv[j][i] = w;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int wr0;
        int d0;
        logic [15:0] exp_y [BCK];

        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        check("rst_we",   32'(ram_we),   32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(16'h0100, 16'h0080);
        run_layer("unity", 16'h0000, 16'h0100, 16'h0200);
        check_const("unity", 16'h0200, 16'h0500);

        fill(16'h7FFF, 16'h7FFF);
        run_layer("satpos", 16'h0000, 16'h0100, 16'h0200);
        check_const("satpos", 16'h0200, 16'h7FFF);

        fill(16'h7FFF, 16'h8000);
        run_layer("satneg", 16'h0000, 16'h0100, 16'h0200);
        check_const("satneg", 16'h0200, 16'h8000);

        fill(16'h0000, 16'h0001);
        xv[0] = 16'hFF80;
        run_layer("trunc", 16'h0000, 16'h0100, 16'h0200);
        check_const("trunc", 16'h0200, 16'hFFFF);

        for (int i = 0; i < FRT; i++) begin
            xv[i] = 16'(i*300 - 1200);
            for (int j = 0; j < BCK; j++) wv[j][i] = 16'((j+1)*50 - i*20);
        end
        for (int j = 0; j < BCK; j++) exp_y[j] = golden(j);
        rd_chk = 1'b1;
        run_layer("wrap", 16'hFFFC, 16'h0100, 16'h0200);
        rd_chk = 1'b0;
        for (int j = 0; j < BCK; j++) check($sformatf("wrap_y%0d", j), 32'(mem[16'(16'h0200 + j)]), 32'(exp_y[j]));
        check("wrap_bad_rd", 32'(bad_rd), 32'd0);

        // start pulses mid-layer, in the last WRITE and in DONE are ignored
        fill(16'h0100, 16'h0080);
        load_layer(16'h0000, 16'h0100, 16'h0200);
        d0 = done_cnt;
        start_layer(16'h0000, 16'h0100, 16'h0200);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == 20 || cyc == 155 || cyc == 156);
        end
        check("ign_done_cyc", 32'(cyc), 32'd156);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy_after", 32'(busy), 32'd0);
        check("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_const("ign", 16'h0200, 16'h0500);
        wr_lo    = 16'h0300;
        wr_hi    = 16'h0304;
        in_base  = 16'h0000;
        w_base   = 16'h0100;
        out_base = 16'h0300;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_c1", 32'(busy), 32'd1);
        wait_done(1, cyc);
        check("b2b_done_cyc", 32'(cyc), 32'd156);
        for (int j = 0; j < BCK; j++) check($sformatf("b2b_y%0d", j), 32'(mem[16'(16'h0300 + j)]), 32'h0500);
        wr_lo = 16'h0200;
        wr_hi = 16'h0204;

        // reset asserted while neuron 1 is accumulating
        fill(16'h0100, 16'h0080);
        load_layer(16'h0000, 16'h0100, 16'h0200);
        wr0 = wr_cnt;
        start_layer(16'h0000, 16'h0100, 16'h0200);
        cyc = 1;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        check("mrst_we",   32'(ram_we),   32'd0);
        check("mrst_busy", 32'(busy),     32'd0);
        check("mrst_addr", 32'(ram_addr), 32'd0);
        check("mrst_data", 32'(ram_data), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("mrst_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("mrst_y0", 32'(mem[16'h0200]), 32'h0500);
        for (int j = 1; j < BCK; j++) check($sformatf("mrst_y%0d", j), 32'(mem[16'(16'h0200 + j)]), 32'h0000DEAD);
        run_layer("post_rst", 16'h0000, 16'h0100, 16'h0200);
        check_const("post_rst", 16'h0200, 16'h0500);

        check("bad_wr", 32'(bad_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
